// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: active-low gfedcba digit
// codes, blank/off patterns and the scan state encoding.
package seg7_pkg;

  localparam int DIGIT_W = 7;

  localparam logic [6:0] ZERO  = 7'b1000000;
  localparam logic [6:0] ONE   = 7'b1111001;
  localparam logic [6:0] TWO   = 7'b0100100;
  localparam logic [6:0] THREE = 7'b0110000;
  localparam logic [6:0] FOUR  = 7'b0011001;
  localparam logic [6:0] FIVE  = 7'b0010010;
  localparam logic [6:0] SIX   = 7'b0000010;
  localparam logic [6:0] SEVEN = 7'b1111000;
  localparam logic [6:0] EIGHT = 7'b0000000;
  localparam logic [6:0] NINE  = 7'b0010000;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  function automatic logic [6:0] digit_field(input logic [27:0] word, input logic [1:0] idx);
    return word[idx*DIGIT_W +: DIGIT_W];
  endfunction

endpackage

// File: rtl/seg7_scan_driver_scan_tick_gen.sv
// Free-running slot counter 0..REFRESH_DIV-1; tick is high during the terminal
// count so the consumer acts on the edge that wraps the counter.
module scan_tick_gen #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver with per-frame snapshot, leading-zero
// blanking and an optional frame-counted blink enabled by SEG7_BLINK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [27:0] display_all,
  input  logic        blank_lz,
  input  logic        blink,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [27:0] snap_q, snap_d;
  logic        blz_q, blz_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        ft_q, ft_d;
  logic        dp_q;
  logic        tick_s, load_s;
  logic [3:0]  lz_blank_s;
  logic [6:0]  dig_s;

  scan_tick_gen #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load_s  = 1'b0;
    if (tick_s) begin
      if (state_q == IDLE) begin
        state_d = SCAN;
        idx_d   = 2'd0;
        load_s  = 1'b1;
      end else begin
        idx_d  = idx_q + 2'd1;
        load_s = (idx_q == 2'd3);
      end
    end else begin
      load_s = 1'b0;
    end
    if (load_s) begin
      snap_d = display_all;
      blz_d  = blank_lz;
    end else begin
      snap_d = snap_q;
      blz_d  = blz_q;
    end
    ft_d = load_s;
  end

`ifdef SEG7_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          brun_q, brun_d;
  logic          phase_q, phase_d;

  // The first frame that samples blink=1 is frame 0 of the ON phase.
  always_comb begin
    bcnt_d  = bcnt_q;
    brun_d  = brun_q;
    phase_d = phase_q;
    if (load_s) begin
      if (!blink) begin
        bcnt_d  = '0;
        brun_d  = 1'b0;
        phase_d = 1'b1;
      end else if (!brun_q) begin
        bcnt_d  = '0;
        brun_d  = 1'b1;
        phase_d = 1'b1;
      end else if (bcnt_q == BLINK_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end else begin
      bcnt_d = bcnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q  <= '0;
      brun_q  <= 1'b0;
      phase_q <= 1'b1;
    end else begin
      bcnt_q  <= bcnt_d;
      brun_q  <= brun_d;
      phase_q <= phase_d;
    end
  end
`else
  logic phase_d;
  logic blink_unused_s;
  assign phase_d        = 1'b1;
  assign blink_unused_s = blink;
`endif

  // Leading-zero blanking ripples down from digit3 and never reaches digit0.
  always_comb begin
    lz_blank_s[3] = blz_d && (snap_d[27:21] == ZERO);
    lz_blank_s[2] = lz_blank_s[3] && (snap_d[20:14] == ZERO);
    lz_blank_s[1] = lz_blank_s[2] && (snap_d[13:7] == ZERO);
    lz_blank_s[0] = 1'b0;
    dig_s         = digit_field(snap_d, idx_d);
    if (tick_s) begin
      if (lz_blank_s[idx_d]) begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
      end else if (!phase_d) begin
        an_d  = AN_OFF;
        seg_d = dig_s;
      end else begin
        an_d  = ~(4'b0001 << idx_d);
        seg_d = dig_s;
      end
    end else begin
      an_d  = an_q;
      seg_d = seg_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      snap_q  <= 28'hFFFFFFF;
      blz_q   <= 1'b0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_BLANK;
      ft_q    <= 1'b0;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      blz_q   <= blz_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      ft_q    <= ft_d;
      dp_q    <= 1'b1;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver with a cycle-level behavioural model
// derived from elapsed time since reset release.
module tb_seg7_scan_driver;

  localparam int RD = 4;
  localparam int BF = 2;

  localparam logic [6:0] CODES [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                        7'b0000000, 7'b0010000};

  logic        clk;
  logic        rst;
  logic [27:0] display_all;
  logic        blank_lz;
  logic        blink;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int checks;
  int failures;

  int          t;
  logic [27:0] m_snap;
  logic        m_blz;
  int          m_run;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_ft;

  seg7_scan_driver #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .rst         (rst),
    .display_all (display_all),
    .blank_lz    (blank_lz),
    .blink       (blink),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic model_reset();
    t      = 0;
    m_snap = 28'hFFFFFFF;
    m_blz  = 1'b0;
    m_run  = 0;
    m_an   = 4'hF;
    m_seg  = 7'h7F;
    m_ft   = 1'b0;
  endtask

  // Slot s (1-based) ends at edge s*RD after release; it shows digit (s-1) mod 4.
  task automatic model_edge();
    int s;
    int idx;
    logic bl;
    logic on;
    logic [3:0] one_hot;
    if (rst) begin
      model_reset();
    end else begin
      t++;
      m_ft = 1'b0;
      if (t % RD == 0) begin
        s   = t / RD;
        idx = (s - 1) % 4;
        if (idx == 0) begin
          m_snap = display_all;
          m_blz  = blank_lz;
          m_ft   = 1'b1;
          if (blink) m_run++;
          else m_run = 0;
        end
        bl = m_blz && (idx > 0);
        for (int j = idx; j < 4; j++) begin
          if (m_snap[j*7 +: 7] != 7'b1000000) bl = 1'b0;
        end
`ifdef SEG7_BLINK_EN
        on = (m_run == 0) || ((((m_run - 1) / BF) % 2) == 0);
`else
        on = 1'b1;
`endif
        one_hot = 4'b0001 << idx;
        m_an  = (bl || !on) ? 4'hF : ~one_hot;
        m_seg = bl ? 7'h7F : m_snap[idx*7 +: 7];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("an", {28'd0, an}, {28'd0, m_an});
    chk("seg", {25'd0, seg}, {25'd0, m_seg});
    chk("dp", {31'd0, dp}, 32'd1);
    chk("frame_tick", {31'd0, frame_tick}, {31'd0, m_ft});
  endtask

  function automatic logic [6:0] rand_digit();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return CODES[0];
    else if (r < 8) return CODES[$urandom_range(0, 9)];
    else return 7'($urandom_range(0, 127));
  endfunction

  initial begin
    int lit;
    int dark;
    checks      = 0;
    failures    = 0;
    clk         = 1'b0;
    rst         = 1'b1;
    display_all = {CODES[1], CODES[2], CODES[3], CODES[4]};
    blank_lz    = 1'b0;
    blink       = 1'b0;
    model_reset();

    for (int k = 0; k < 3; k++) step();
    chk("reset_an", {28'd0, an}, 32'hF);
    chk("reset_seg", {25'd0, seg}, 32'h7F);

    // Basic scan order and mid-frame input change.
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 4) begin
        chk("c4_an", {28'd0, an}, 32'b1110);
        chk("c4_seg", {25'd0, seg}, 32'b0011001);
        chk("c4_ft", {31'd0, frame_tick}, 32'd1);
      end
      if (k == 5) chk("c5_ft", {31'd0, frame_tick}, 32'd0);
      if (k == 8) begin
        chk("c8_an", {28'd0, an}, 32'b1101);
        chk("c8_seg", {25'd0, seg}, 32'b0110000);
      end
      if (k == 9) display_all = {CODES[9], CODES[8], CODES[7], CODES[6]};
      if (k == 12) begin
        chk("c12_an", {28'd0, an}, 32'b1011);
        chk("c12_seg", {25'd0, seg}, 32'b0100100);
      end
      if (k == 16) begin
        chk("c16_an", {28'd0, an}, 32'b0111);
        chk("c16_seg", {25'd0, seg}, 32'b1111001);
      end
      if (k == 20) begin
        chk("c20_ft", {31'd0, frame_tick}, 32'd1);
        chk("c20_seg", {25'd0, seg}, 32'b0000010);
      end
    end

    // Leading-zero blanking: all zeros, then only digit3 zero.
    display_all = {4{CODES[0]}};
    blank_lz    = 1'b1;
    for (int k = 0; k < 16; k++) step();
    lit = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (an != 4'hF) lit++;
    end
    chk("lz_all_zero_lit", lit, 32'd4);
    chk("lz_all_zero_d0", {25'd0, seg}, {25'd0, m_seg});

    display_all = {CODES[0], CODES[5], CODES[0], CODES[7]};
    for (int k = 0; k < 16; k++) step();
    lit = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (an != 4'hF) lit++;
    end
    chk("lz_0507_lit", lit, 32'd12);

    // Blink: in steady state half of every 4-frame window is dark.
    blank_lz    = 1'b0;
    display_all = {CODES[1], CODES[2], CODES[3], CODES[4]};
    blink       = 1'b1;
    for (int k = 0; k < 64; k++) step();
    dark = 0;
    for (int k = 0; k < 64; k++) begin
      step();
      if (an == 4'hF) dark++;
    end
`ifdef SEG7_BLINK_EN
    chk("blink_dark", dark, 32'd32);
`else
    chk("blink_dark", dark, 32'd0);
`endif
    blink = 1'b0;
    for (int k = 0; k < 16; k++) step();
    dark = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (an == 4'hF) dark++;
    end
    chk("blink_off_dark", dark, 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 6) == 0)
        display_all = {rand_digit(), rand_digit(), rand_digit(), rand_digit()};
      if ($urandom_range(0, 19) == 0) blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) blink = 1'($urandom_range(0, 1));
      step();
    end

    // Reset during the digit2 slot, then restart from digit0.
    display_all = {CODES[1], CODES[2], CODES[3], CODES[4]};
    blank_lz    = 1'b0;
    blink       = 1'b0;
    begin
      bit found;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
        step();
        if (t >= RD && (t % RD) == 1 && (((t / RD) - 1) % 4) == 2) found = 1'b1;
      end
      chk("rst_slot_found", {31'd0, found}, 32'd1);
    end
    rst = 1'b1;
    #1;
    chk("rst_async_an", {28'd0, an}, 32'hF);
    chk("rst_async_seg", {25'd0, seg}, 32'h7F);
    chk("rst_async_ft", {31'd0, frame_tick}, 32'd0);
    model_reset();
    step();
    step();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k == 3) chk("restart_c3_an", {28'd0, an}, 32'hF);
    end
    chk("restart_an", {28'd0, an}, 32'b1110);
    chk("restart_seg", {25'd0, seg}, 32'b0011001);
    chk("restart_ft", {31'd0, frame_tick}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
